// File: rtl/chacha20_serial_decoder.sv
// ChaCha20 (RFC 8439) receive-side block decryptor.
// One quarter-round per clock on a 16-word working state; the keystream
// (working + initial state) is XORed with a latched 512-bit ciphertext block.
// The block counter advances on every accepted plaintext handshake and a
// sticky flag records a 0xFFFFFFFF -> 0 wrap.
// ROUNDS must be even: the schedule alternates column and diagonal rounds.

module chacha20_serial_decoder #(
  parameter int ROUNDS = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         set_key,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter_init,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] ciphertext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] plaintext,
  output logic         counter_wrapped
);

  localparam int QR_TOTAL = 4 * ROUNDS;
  localparam int CNT_W    = $clog2(QR_TOTAL);
  localparam logic [CNT_W-1:0] QR_LAST = CNT_W'(QR_TOTAL - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROUND  = 2'd1;
  localparam logic [1:0] S_FINAL  = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  logic [1:0]       stateQ, stateD;
  logic [255:0]     keyQ, keyD;
  logic [95:0]      nonceQ, nonceD;
  logic [31:0]      counterQ, counterD;
  logic             wrappedQ, wrappedD;
  logic [CNT_W-1:0] qrCntQ, qrCntD;
  logic [511:0]     ctQ, ctD;
  logic [511:0]     ptQ, ptD;
  logic [31:0]      workQ [16];
  logic [31:0]      workD [16];

  logic [255:0]     effKey;
  logic [95:0]      effNonce;
  logic [31:0]      effCounter;
  logic [31:0]      initState [16];

  logic [3:0]       idxA, idxB, idxC, idxD;
  logic [31:0]      qrA, qrB, qrC, qrD;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    rotl = (v << n) | (v >> (32 - n));
  endfunction

  // A key load in the same IDLE cycle as a block acceptance must feed that
  // block, so the initial state is built from the incoming key in that case.
  always_comb begin
    effKey     = keyQ;
    effNonce   = nonceQ;
    effCounter = counterQ;
    if (stateQ == S_IDLE && set_key) begin
      effKey     = key;
      effNonce   = nonce;
      effCounter = counter_init;
    end
    initState[0]  = 32'h61707865;
    initState[1]  = 32'h3320646e;
    initState[2]  = 32'h79622d32;
    initState[3]  = 32'h6b206574;
    for (int i = 0; i < 8; i++) begin
      initState[4 + i] = effKey[32*i +: 32];
    end
    initState[12] = effCounter;
    initState[13] = effNonce[31:0];
    initState[14] = effNonce[63:32];
    initState[15] = effNonce[95:64];
  end

  // Select the four words for this cycle's quarter-round and compute it.
  // Columns use word i of each row; diagonals rotate rows 1..3 by 1..3.
  always_comb begin
    logic       diag;
    logic [1:0] lane;
    logic [31:0] a, b, c, d;
    diag = qrCntQ[2];
    lane = qrCntQ[1:0];
    idxA = {2'b00, lane};
    idxB = {2'b01, lane + (diag ? 2'd1 : 2'd0)};
    idxC = {2'b10, lane + (diag ? 2'd2 : 2'd0)};
    idxD = {2'b11, lane + (diag ? 2'd3 : 2'd0)};
    a = workQ[idxA];
    b = workQ[idxB];
    c = workQ[idxC];
    d = workQ[idxD];
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    qrA = a;
    qrB = b;
    qrC = c;
    qrD = d;
  end

  // Next-state logic for the FSM and all datapath registers; clear forces
  // the same values as reset and overrides everything else.
  always_comb begin
    stateD   = stateQ;
    keyD     = keyQ;
    nonceD   = nonceQ;
    counterD = counterQ;
    wrappedD = wrappedQ;
    qrCntD   = qrCntQ;
    ctD      = ctQ;
    ptD      = ptQ;
    workD    = workQ;

    case (stateQ)
      S_IDLE: begin
        if (set_key) begin
          keyD     = key;
          nonceD   = nonce;
          counterD = counter_init;
          wrappedD = 1'b0;
        end
        if (in_valid) begin
          ctD    = ciphertext;
          workD  = initState;
          qrCntD = '0;
          stateD = S_ROUND;
        end
      end
      S_ROUND: begin
        workD[idxA] = qrA;
        workD[idxB] = qrB;
        workD[idxC] = qrC;
        workD[idxD] = qrD;
        qrCntD      = qrCntQ + 1'b1;
        if (qrCntQ == QR_LAST) begin
          stateD = S_FINAL;
        end
      end
      S_FINAL: begin
        for (int i = 0; i < 16; i++) begin
          ptD[32*i +: 32] = (workQ[i] + initState[i]) ^ ctQ[32*i +: 32];
        end
        stateD = S_OUTPUT;
      end
      default: begin
        if (out_ready) begin
          counterD = counterQ + 32'd1;
          if (counterQ == 32'hFFFF_FFFF) begin
            wrappedD = 1'b1;
          end
          stateD = S_IDLE;
        end
      end
    endcase

    if (clear) begin
      stateD   = S_IDLE;
      keyD     = '0;
      nonceD   = '0;
      counterD = '0;
      wrappedD = 1'b0;
      qrCntD   = '0;
      ctD      = '0;
      ptD      = '0;
      for (int i = 0; i < 16; i++) begin
        workD[i] = '0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ   <= S_IDLE;
      keyQ     <= '0;
      nonceQ   <= '0;
      counterQ <= '0;
      wrappedQ <= 1'b0;
      qrCntQ   <= '0;
      ctQ      <= '0;
      ptQ      <= '0;
      for (int i = 0; i < 16; i++) begin
        workQ[i] <= '0;
      end
    end else begin
      stateQ   <= stateD;
      keyQ     <= keyD;
      nonceQ   <= nonceD;
      counterQ <= counterD;
      wrappedQ <= wrappedD;
      qrCntQ   <= qrCntD;
      ctQ      <= ctD;
      ptQ      <= ptD;
      for (int i = 0; i < 16; i++) begin
        workQ[i] <= workD[i];
      end
    end
  end

  assign in_ready        = (stateQ == S_IDLE);
  assign out_valid       = (stateQ == S_OUTPUT);
  assign plaintext       = ptQ;
  assign counter_wrapped = wrappedQ;

endmodule

// File: tb/tb_chacha20_serial_decoder.sv
// Scoreboard bench for chacha20_serial_decoder: stimulus pushes expected
// plaintext, a negedge monitor pops and compares on each handshake.

module tb_chacha20_serial_decoder;

  logic         clock;
  logic         reset;
  logic         clear;
  logic         set_key;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter_init;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] ciphertext;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] plaintext;
  logic         counter_wrapped;

  int testsRun = 0;
  int testsFailed = 0;
  logic [511:0] sb [$];
  int cyc = 0;
  int acceptCyc = 0;
  logic prevOv = 1'b0;

  logic [255:0] rfcKey;
  logic [95:0]  nonce1, nonce2;
  logic [511:0] exp1, ct2, pt2, ct3, exp3, ks;

  logic [31:0] rfcWords [16] = '{
    32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
    32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
    32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
    32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

  logic [7:0] ct2Bytes [64] = '{
    8'h6e, 8'h2e, 8'h35, 8'h9a, 8'h25, 8'h68, 8'hf9, 8'h80,
    8'h41, 8'hba, 8'h07, 8'h28, 8'hdd, 8'h0d, 8'h69, 8'h81,
    8'he9, 8'h7e, 8'h7a, 8'hec, 8'h1d, 8'h43, 8'h60, 8'hc2,
    8'h0a, 8'h27, 8'haf, 8'hcc, 8'hfd, 8'h9f, 8'hae, 8'h0b,
    8'hf9, 8'h1b, 8'h65, 8'hc5, 8'h52, 8'h47, 8'h33, 8'hab,
    8'h8f, 8'h59, 8'h3d, 8'hab, 8'hcd, 8'h62, 8'hb3, 8'h57,
    8'h16, 8'h39, 8'hd6, 8'h24, 8'he6, 8'h51, 8'h52, 8'hab,
    8'h8f, 8'h53, 8'h0c, 8'h35, 8'h9f, 8'h08, 8'h61, 8'hd8};

  logic [7:0] ct3Bytes [50] = '{
    8'h07, 8'hca, 8'h0d, 8'hbf, 8'h50, 8'h0d, 8'h6a, 8'h61,
    8'h56, 8'ha3, 8'h8e, 8'h08, 8'h8a, 8'h22, 8'hb6, 8'h5e,
    8'h52, 8'hbc, 8'h51, 8'h4d, 8'h16, 8'hcc, 8'hf8, 8'h06,
    8'h81, 8'h8c, 8'he9, 8'h1a, 8'hb7, 8'h79, 8'h37, 8'h36,
    8'h5a, 8'hf9, 8'h0b, 8'hbf, 8'h74, 8'ha3, 8'h5b, 8'he6,
    8'hb4, 8'h0b, 8'h8e, 8'hed, 8'hf2, 8'h78, 8'h5e, 8'h42,
    8'h87, 8'h4d};

  string text2 = "Ladies and Gentlemen of the class of '99: If I could offer you o";
  string text3 = "nly one tip for the future, sunscreen would be it.";

  chacha20_serial_decoder #(.ROUNDS(20)) dut (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .set_key(set_key),
    .key(key),
    .nonce(nonce),
    .counter_init(counter_init),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ciphertext(ciphertext),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .plaintext(plaintext),
    .counter_wrapped(counter_wrapped)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Global watchdog so a stuck design cannot hang the run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] refQr(input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Reference ChaCha20 block function (RFC 8439 section 2.3), 10 double rounds.
  function automatic logic [511:0] refKeystream(input logic [255:0] k,
                                                 input logic [95:0] n,
                                                 input logic [31:0] c);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [127:0] t;
    logic [511:0] r;
    int qi [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                      '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
    s[12] = c;
    s[13] = n[31:0];
    s[14] = n[63:32];
    s[15] = n[95:64];
    x = s;
    for (int dr = 0; dr < 10; dr++) begin
      for (int q = 0; q < 8; q++) begin
        t = refQr(x[qi[q][0]], x[qi[q][1]], x[qi[q][2]], x[qi[q][3]]);
        x[qi[q][0]] = t[127:96];
        x[qi[q][1]] = t[95:64];
        x[qi[q][2]] = t[63:32];
        x[qi[q][3]] = t[31:0];
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle counter and acceptance timestamp for the latency check.
  always @(posedge clock) begin
    if (reset && in_valid && in_ready) acceptCyc = cyc;
    cyc = cyc + 1;
  end

  // Monitor: latency on each out_valid rise, plaintext on each handshake.
  always @(negedge clock) begin
    if (reset && out_valid && !prevOv) checkOutput("latency", 512'(cyc - acceptCyc), 512'd82);
    prevOv = reset && out_valid;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", 512'd1, 512'd0);
      end else begin
        checkOutput("plaintext", plaintext, sb.pop_front());
      end
    end
  end

  task automatic loadKey(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    key = k; nonce = n; counter_init = c; set_key = 1'b1;
    @(posedge clock); #1;
    set_key = 1'b0; key = '0; nonce = '0; counter_init = '0;
  endtask

  // Offer one block (optionally with a simultaneous key load still set up by
  // the caller) and queue its expected plaintext.
  task automatic applyStimulus(input logic [511:0] ct, input logic [511:0] exp, input bit doPush);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("in_ready_wait", 512'(in_ready), 512'd1);
    in_valid = 1'b1;
    ciphertext = ct;
    if (doPush) sb.push_back(exp);
    @(posedge clock); #1;
    in_valid = 1'b0;
    set_key = 1'b0;
    ciphertext = '0;
    checkOutput("in_ready_busy", 512'(in_ready), 512'd0);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("drain", 512'(sb.size()), 512'd0);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; set_key = 1'b0; key = '0; nonce = '0;
    counter_init = '0; in_valid = 1'b0; ciphertext = '0; out_ready = 1'b1;

    for (int j = 0; j < 32; j++) rfcKey[8*j +: 8] = 8'(j);
    nonce1 = {32'h00000000, 32'h4a000000, 32'h09000000};
    nonce2 = {32'h00000000, 32'h4a000000, 32'h00000000};
    for (int i = 0; i < 16; i++) exp1[32*i +: 32] = rfcWords[i];
    for (int j = 0; j < 64; j++) begin
      ct2[8*j +: 8] = ct2Bytes[j];
      pt2[8*j +: 8] = text2[j];
    end
    ks = refKeystream(rfcKey, nonce2, 32'd2);
    for (int j = 0; j < 64; j++) begin
      ct3[8*j +: 8]  = (j < 50) ? ct3Bytes[j] : 8'h00;
      exp3[8*j +: 8] = (j < 50) ? text3[j] : ks[8*j +: 8];
    end

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_in_ready", 512'(in_ready), 512'd1);
    checkOutput("rst_out_valid", 512'(out_valid), 512'd0);
    checkOutput("rst_plaintext", plaintext, 512'd0);
    checkOutput("rst_wrapped", 512'(counter_wrapped), 512'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    $display("[TB] test 1: RFC 8439 2.3.2 keystream");
    loadKey(rfcKey, nonce1, 32'd1);
    applyStimulus(512'd0, exp1, 1'b1);
    waitDrain();

    $display("[TB] test 2/3: RFC 8439 2.4.2 blocks back-to-back, key loaded with block");
    key = rfcKey; nonce = nonce2; counter_init = 32'd1; set_key = 1'b1;
    applyStimulus(ct2, pt2, 1'b1);
    key = '0; nonce = '0; counter_init = '0;
    applyStimulus(ct3, exp3, 1'b1);
    waitDrain();

    $display("[TB] test 4: backpressure on output");
    loadKey(rfcKey, nonce1, 32'd1);
    out_ready = 1'b0;
    applyStimulus(512'd0, exp1, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 200) begin
        @(posedge clock); #1;
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_valid", 512'(out_valid), 512'd1);
      checkOutput("hold_plaintext", plaintext, exp1);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    waitDrain();
    applyStimulus(512'd0, refKeystream(rfcKey, nonce1, 32'd2), 1'b1);
    waitDrain();

    $display("[TB] test 5: counter wrap");
    loadKey(rfcKey, nonce1, 32'hFFFF_FFFF);
    applyStimulus(512'd0, refKeystream(rfcKey, nonce1, 32'hFFFF_FFFF), 1'b1);
    waitDrain();
    checkOutput("wrapped_set", 512'(counter_wrapped), 512'd1);
    applyStimulus(512'd0, refKeystream(rfcKey, nonce1, 32'd0), 1'b1);
    waitDrain();
    checkOutput("wrapped_sticky", 512'(counter_wrapped), 512'd1);
    loadKey(rfcKey, nonce1, 32'd5);
    checkOutput("wrapped_cleared", 512'(counter_wrapped), 512'd0);

    $display("[TB] test 6a: synchronous clear mid-round");
    applyStimulus(512'd0, 512'd0, 1'b0);
    repeat (20) @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    checkOutput("clr_out_valid", 512'(out_valid), 512'd0);
    checkOutput("clr_in_ready", 512'(in_ready), 512'd1);
    checkOutput("clr_plaintext", plaintext, 512'd0);
    applyStimulus(512'd0, refKeystream(256'd0, 96'd0, 32'd0), 1'b1);
    waitDrain();

    $display("[TB] test 6b: async reset mid-round then rerun");
    loadKey(rfcKey, nonce1, 32'd1);
    applyStimulus(512'd0, 512'd0, 1'b0);
    repeat (39) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("arst_out_valid", 512'(out_valid), 512'd0);
    checkOutput("arst_in_ready", 512'(in_ready), 512'd1);
    checkOutput("arst_plaintext", plaintext, 512'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    loadKey(rfcKey, nonce1, 32'd1);
    applyStimulus(512'd0, exp1, 1'b1);
    waitDrain();

    repeat (5) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
